// File: rtl/cpmg_echo_acq_pkg.sv
`default_nettype none
// ============================================================================
//  cpmg_pkg : shared types and constants for the CPMG generator/receiver pair
//  Rev 1.0
// ============================================================================
package cpmg_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_FIRST = 3'd2,
        S_BLANK = 3'd3,
        S_ACQ   = 3'd4,
        S_WAIT  = 3'd5,
        S_DONE  = 3'd6
    } state_e;

    localparam logic [15:0] HIGH_VALUE    = 16'h7FF8;
    localparam logic [15:0] LOW_VALUE     = 16'h0000;
    localparam int          SUM_W_DEFAULT = 40;

endpackage : cpmg_pkg
`default_nettype wire

// File: rtl/cpmg_echo_acq_accum.sv
`default_nettype none
// ============================================================================
//  echo_accum : signed window accumulator with sample counter and full flag
//  Rev 1.0
// ============================================================================
module echo_accum #(
    parameter int SUM_W = 40,
    parameter int ADC_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic signed [ADC_W-1:0] sample_i,
    input  logic [15:0]             win_len_i,
    output logic signed [SUM_W-1:0] sum_o,
    output logic                    win_full_o
);

    logic signed [SUM_W-1:0] sum_q, sum_d, ext_w;
    logic [15:0]             cnt_q, cnt_d;

    assign ext_w = {{(SUM_W-ADC_W){sample_i[ADC_W-1]}}, sample_i};

    // clear together with enable restarts the window on the current sample
    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            sum_d = en_i ? ext_w : '0;
            cnt_d = en_i ? 16'd1 : 16'd0;
        end else if (en_i) begin
            sum_d = sum_q + ext_w;
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end

    assign sum_o      = sum_q;
    assign win_full_o = (cnt_q == win_len_i);

endmodule : echo_accum
`default_nettype wire

// File: rtl/cpmg_echo_acq.sv
`default_nettype none
// ============================================================================
//  cpmg_echo_acq : opens one ADC summing window per CPMG refocusing pulse
//  Rev 1.0
// ============================================================================
module cpmg_echo_acq
    import cpmg_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEFAULT,
    parameter int ADC_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arm,
    input  logic [15:0]             tx_data,
    input  logic signed [ADC_W-1:0] adc_data,
    input  logic [31:0]             blank_cycles,
    input  logic [15:0]             win_len,
    input  logic [15:0]             num_echoes,
    output logic signed [SUM_W-1:0] echo_sum,
    output logic [15:0]             echo_idx,
    output logic                    echo_trunc,
    output logic                    echo_valid,
    input  logic                    echo_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun
);

    state_e                  state_q, state_d;
    logic                    pulse_q, pulse_d1_q;
    logic signed [ADC_W-1:0] adc_q;
    logic [31:0]             blank_cfg_q, blank_q, blank_d;
    logic [15:0]             win_cfg_q, num_cfg_q, seq_cnt_q, seq_d;
    logic                    fall_w, rise_w, win_full_w;
    logic                    acc_clr_w, acc_en_w, emit_w, emit_trunc_w;
    logic signed [SUM_W-1:0] acc_sum_w;
    logic signed [SUM_W-1:0] sum_q;
    logic [15:0]             idx_q;
    logic                    trunc_q, valid_q, overrun_q;

    assign fall_w = pulse_d1_q & ~pulse_q;
    assign rise_w = pulse_q & ~pulse_d1_q;

    echo_accum #(.SUM_W(SUM_W), .ADC_W(ADC_W)) u_accum (
        .clk_i      (clk),
        .rst_n_i    (rst),
        .clr_i      (acc_clr_w),
        .en_i       (acc_en_w),
        .sample_i   (adc_q),
        .win_len_i  (win_cfg_q),
        .sum_o      (acc_sum_w),
        .win_full_o (win_full_w)
    );

    always_comb begin
        state_d      = state_q;
        blank_d      = blank_q;
        seq_d        = seq_cnt_q;
        acc_clr_w    = 1'b0;
        acc_en_w     = 1'b0;
        emit_w       = 1'b0;
        emit_trunc_w = 1'b0;
        if (arm) begin
            acc_clr_w = 1'b1;
            seq_d     = 16'd0;
            state_d   = (num_echoes == 16'd0) ? S_DONE : S_ARMED;
        end else begin
            case (state_q)
                S_ARMED: if (fall_w) state_d = S_FIRST;
                // the falling-edge cycle itself is the first blanking cycle
                S_FIRST, S_WAIT: begin
                    if (fall_w) begin
                        acc_clr_w = 1'b1;
                        if (blank_cfg_q == 32'd0) begin
                            acc_en_w = 1'b1;
                            state_d  = S_ACQ;
                        end else if (blank_cfg_q == 32'd1) begin
                            state_d = S_ACQ;
                        end else begin
                            blank_d = blank_cfg_q - 32'd1;
                            state_d = S_BLANK;
                        end
                    end
                end
                S_BLANK: begin
                    if (rise_w) begin
                        emit_w       = 1'b1;
                        emit_trunc_w = 1'b1;
                    end else if (blank_q == 32'd1) begin
                        state_d = S_ACQ;
                    end else begin
                        blank_d = blank_q - 32'd1;
                    end
                end
                S_ACQ: begin
                    if (win_full_w) begin
                        emit_w = 1'b1;
                    end else if (rise_w) begin
                        emit_w       = 1'b1;
                        emit_trunc_w = 1'b1;
                    end else begin
                        acc_en_w = 1'b1;
                    end
                end
                default: ;
            endcase
            if (emit_w) begin
                acc_clr_w = 1'b1;
                seq_d     = seq_cnt_q + 16'd1;
                state_d   = (seq_cnt_q == num_cfg_q - 16'd1) ? S_DONE : S_WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pulse_q     <= 1'b0;
            pulse_d1_q  <= 1'b0;
            adc_q       <= '0;
            blank_cfg_q <= '0;
            win_cfg_q   <= 16'd1;
            num_cfg_q   <= '0;
            blank_q     <= '0;
            seq_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            pulse_q    <= (tx_data != LOW_VALUE);
            pulse_d1_q <= pulse_q;
            adc_q      <= adc_data;
            blank_q    <= blank_d;
            seq_cnt_q  <= seq_d;
            if (arm) begin
                blank_cfg_q <= blank_cycles;
                win_cfg_q   <= (win_len == 16'd0) ? 16'd1 : win_len;
                num_cfg_q   <= num_echoes;
            end
        end
    end

    // one-entry holding register; a result arriving while blocked is dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q     <= '0;
            idx_q     <= '0;
            trunc_q   <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (arm) begin
            idx_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (emit_w && (!valid_q || echo_ready)) begin
            sum_q   <= acc_sum_w;
            idx_q   <= seq_cnt_q;
            trunc_q <= emit_trunc_w;
            valid_q <= 1'b1;
        end else begin
            if (emit_w)
                overrun_q <= 1'b1;
            if (valid_q && echo_ready)
                valid_q <= 1'b0;
        end
    end

    assign echo_sum   = sum_q;
    assign echo_idx   = idx_q;
    assign echo_trunc = trunc_q;
    assign echo_valid = valid_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);

endmodule : cpmg_echo_acq
`default_nettype wire

// File: tb/tb_cpmg_echo_acq.sv
`default_nettype none
// ============================================================================
//  tb_cpmg_echo_acq : directed self-checking bench for cpmg_echo_acq
//  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_cpmg_echo_acq;
    import cpmg_pkg::*;

    localparam int SUM_W = 40;
    localparam int ADC_W = 16;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    arm = 1'b0;
    logic                    echo_ready = 1'b1;
    logic [15:0]             tx_data = 16'd0;
    logic signed [ADC_W-1:0] adc_data = '0;
    logic [31:0]             blank_cycles = 32'd3;
    logic [15:0]             win_len = 16'd8;
    logic [15:0]             num_echoes = 16'd4;
    logic signed [SUM_W-1:0] echo_sum;
    logic [15:0]             echo_idx;
    logic                    echo_trunc, echo_valid, busy, done, overrun;

    int     vecs = 0, errs = 0, cyc = 0;
    logic   vld_prev = 1'b0, done_prev = 1'b0;
    int     rise_q[$];
    longint sum_log[$];
    int     idx_log[$];
    int     trunc_log[$];
    int     done_cyc = -1;
    int     t_fall = 0, t_rise = 0, t0 = 0;

    cpmg_echo_acq #(.SUM_W(SUM_W), .ADC_W(ADC_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .arm          (arm),
        .tx_data      (tx_data),
        .adc_data     (adc_data),
        .blank_cycles (blank_cycles),
        .win_len      (win_len),
        .num_echoes   (num_echoes),
        .echo_sum     (echo_sum),
        .echo_idx     (echo_idx),
        .echo_trunc   (echo_trunc),
        .echo_valid   (echo_valid),
        .echo_ready   (echo_ready),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    always #4 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // transfers are logged just before the edge that completes them
    task automatic tick();
        if (echo_valid && echo_ready) begin
            sum_log.push_back(echo_sum);
            idx_log.push_back(echo_idx);
            trunc_log.push_back(echo_trunc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (echo_valid && !vld_prev) rise_q.push_back(cyc);
        if (done && !done_prev) done_cyc = cyc;
        vld_prev  = echo_valid;
        done_prev = done;
    endtask

    task automatic clear_log();
        rise_q.delete();
        sum_log.delete();
        idx_log.delete();
        trunc_log.delete();
        done_cyc = -1;
    endtask

    task automatic do_arm(input int b, input int w, input int n);
        blank_cycles = 32'(b);
        win_len      = 16'(w);
        num_echoes   = 16'(n);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        clear_log();
    endtask

    task automatic pulse(input int hi, input int lo, input logic signed [15:0] s);
        adc_data = s;
        tx_data  = HIGH_VALUE;
        t_rise   = cyc;
        repeat (hi) tick();
        tx_data  = LOW_VALUE;
        t_fall   = cyc;
        repeat (lo) tick();
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst_sum", echo_sum, 0);
        chk("rst_valid", echo_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b1;
        tick();

        // four full windows of constant positive samples
        do_arm(3, 8, 4);
        chk("armed_busy", busy, 1);
        pulse(4, 10, 0);
        pulse(8, 20, 100);
        t0 = t_fall;
        repeat (3) pulse(8, 20, 100);
        repeat (5) tick();
        chk("t1_count", sum_log.size(), 4);
        for (int i = 0; i < 4 && i < sum_log.size(); i++) begin
            chk("t1_sum", sum_log[i], 800);
            chk("t1_idx", idx_log[i], i);
            chk("t1_trunc", trunc_log[i], 0);
        end
        chk("t1_latency", (rise_q.size() > 0) ? rise_q[0] - t0 : -1, 13);
        chk("t1_done_with_last", (rise_q.size() >= 4) ? done_cyc - rise_q[3] : -1, 0);
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        chk("t1_overrun", overrun, 0);

        // negative samples must sign-extend
        do_arm(3, 8, 4);
        pulse(4, 10, 0);
        repeat (4) pulse(8, 20, -5);
        repeat (5) tick();
        chk("t2_count", sum_log.size(), 4);
        for (int i = 0; i < 4 && i < sum_log.size(); i++)
            chk("t2_sum", sum_log[i], -40);

        // window longer than the low period: truncated after 10 samples
        do_arm(30, 20, 2);
        pulse(4, 10, 0);
        pulse(8, 40, 7);
        pulse(8, 40, 7);
        t0 = t_rise;
        pulse(8, 40, 7);
        repeat (5) tick();
        chk("t3_count", sum_log.size(), 2);
        for (int i = 0; i < 2 && i < sum_log.size(); i++) begin
            chk("t3_sum", sum_log[i], 70);
            chk("t3_trunc", trunc_log[i], 1);
            chk("t3_idx", idx_log[i], i);
        end
        chk("t3_trunc_latency", (rise_q.size() > 0) ? rise_q[0] - t0 : -1, 2);

        // pulse returns while still blanking: empty truncated result
        do_arm(30, 20, 1);
        pulse(4, 10, 0);
        pulse(8, 20, 9);
        pulse(8, 20, 9);
        chk("t3b_count", sum_log.size(), 1);
        chk("t3b_sum", (sum_log.size() > 0) ? sum_log[0] : -1, 0);
        chk("t3b_trunc", (trunc_log.size() > 0) ? trunc_log[0] : -1, 1);

        // zero blanking, zero window length: exactly the sample at t
        do_arm(0, 0, 1);
        pulse(4, 10, 0);
        adc_data = 16'sd0;
        tx_data  = HIGH_VALUE;
        repeat (8) tick();
        tx_data  = LOW_VALUE;
        t0       = cyc;
        adc_data = 16'sd55;
        tick();
        adc_data = 16'sd1;
        repeat (10) tick();
        chk("t3c_sum", (sum_log.size() > 0) ? sum_log[0] : -1, 55);
        chk("t3c_latency", (rise_q.size() > 0) ? rise_q[0] - t0 : -1, 3);

        // back-pressure over two results
        do_arm(3, 8, 3);
        pulse(4, 10, 0);
        echo_ready = 1'b0;
        pulse(8, 20, 1);
        pulse(8, 20, 2);
        chk("t4_held_valid", echo_valid, 1);
        chk("t4_held_idx", echo_idx, 0);
        chk("t4_held_sum", echo_sum, 8);
        chk("t4_overrun", overrun, 1);
        echo_ready = 1'b1;
        tick();
        pulse(8, 20, 3);
        repeat (3) tick();
        chk("t4_count", sum_log.size(), 2);
        chk("t4_first_idx", (idx_log.size() > 0) ? idx_log[0] : -1, 0);
        chk("t4_second_idx", (idx_log.size() > 1) ? idx_log[1] : -1, 2);
        chk("t4_second_sum", (sum_log.size() > 1) ? sum_log[1] : -1, 24);
        chk("t4_done", done, 1);

        // re-arm in the middle of echo 1's window
        do_arm(3, 8, 4);
        pulse(4, 10, 0);
        echo_ready = 1'b0;
        pulse(8, 20, 4);
        chk("t5_pre_valid", echo_valid, 1);
        adc_data = 16'sd4;
        tx_data  = HIGH_VALUE;
        repeat (8) tick();
        tx_data  = LOW_VALUE;
        repeat (6) tick();
        do_arm(3, 8, 4);
        chk("t5_valid_cleared", echo_valid, 0);
        chk("t5_busy", busy, 1);
        echo_ready = 1'b1;
        repeat (20) tick();
        chk("t5_no_stray", sum_log.size(), 0);
        pulse(4, 10, 0);
        pulse(8, 20, 6);
        chk("t5_count", sum_log.size(), 1);
        chk("t5_idx", (idx_log.size() > 0) ? idx_log[0] : -1, 0);
        chk("t5_sum", (sum_log.size() > 0) ? sum_log[0] : -1, 48);

        // asynchronous reset during acquisition
        do_arm(3, 8, 4);
        pulse(4, 10, 0);
        echo_ready = 1'b0;
        pulse(8, 20, 100);
        tx_data = HIGH_VALUE;
        repeat (8) tick();
        tx_data = LOW_VALUE;
        repeat (6) tick();
        chk("t6_pre_valid", echo_valid, 1);
        chk("t6_pre_sum", echo_sum, 800);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_sum", echo_sum, 0);
        chk("t6_idx", echo_idx, 0);
        chk("t6_trunc", echo_trunc, 0);
        chk("t6_valid", echo_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_overrun", overrun, 0);
        #2;
        rst = 1'b1;
        echo_ready = 1'b1;
        tick();

        // zero echoes: straight to done, nothing emitted
        do_arm(3, 8, 0);
        chk("t7_done", done, 1);
        chk("t7_busy", busy, 0);
        pulse(4, 10, 0);
        pulse(8, 20, 5);
        chk("t7_count", sum_log.size(), 0);
        chk("t7_valid", echo_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule : tb_cpmg_echo_acq
`default_nettype wire
